phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4, SHALL set the number of pipeline phases per instruction; legal range 2..8.
REQ-002 Parameter CNT_W, default 32, SHALL set the width of the performance counters.
REQ-003 Parameter IDX_W, default $clog2(NUM_STAGES), SHALL set the width of the stage index.
REQ-004 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 i_reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_run  input  1  SHALL be the level request for continuous sequencing.
REQ-007 i_step  input  1  SHALL be a single-cycle pulse requesting exactly one instruction while halted.
REQ-008 i_stall  input  1  SHALL hold the current stage (memory or peripheral not ready).
REQ-009 i_flush  input  1  SHALL abort the current instruction.
REQ-010 o_stage_act  output  NUM_STAGES  SHALL be the one-hot active stage, held while stalled; all-zero when halted.
REQ-011 o_stage_en  output  NUM_STAGES  SHALL equal o_stage_act & ~i_stall & ~i_flush (combinational, stage commit strobe).
REQ-012 o_stage_idx  output  IDX_W  SHALL be the binary index of the active stage.
REQ-013 o_retire  output  1  SHALL pulse for one cycle when the last stage commits.
REQ-014 o_busy  output  1  SHALL be high in RUN or STEP.
REQ-015 o_halted  output  1  SHALL be high in IDLE.
REQ-016 o_retire_cnt  output  CNT_W  SHALL be the retired-instruction count.
REQ-017 o_stall_cnt  output  CNT_W  SHALL be the stalled-cycle count.

Function
REQ-018 FSM SHALL have exactly three states: IDLE, RUN, STEP.
REQ-019 IDLE: i_run=1 SHALL move to RUN with stage 0 active next cycle; otherwise i_step=1 SHALL move to STEP; i_run has priority over i_step.
REQ-020 RUN/STEP: each cycle with i_stall=0 and i_flush=0 SHALL advance the stage by one; the last stage SHALL wrap to 0.
REQ-021 Commit of stage NUM_STAGES-1 SHALL assert o_retire in that same cycle.
REQ-022 At retire in RUN, i_run=0 SHALL go to IDLE; otherwise RUN continues at stage 0 with no bubble.
REQ-023 i_run deasserted mid-instruction SHALL NOT abort; the instruction completes before IDLE.
REQ-024 At retire in STEP, the FSM SHALL go to IDLE; i_step during STEP or RUN SHALL be ignored.
REQ-025 i_flush in RUN/STEP SHALL force stage 0 next cycle, no retire; flush has priority over stall and over last-stage commit.
REQ-026 After a flush, STEP SHALL return to IDLE; RUN SHALL continue only if i_run=1, else IDLE.
REQ-027 i_flush and i_stall in IDLE SHALL have no effect.
REQ-028 o_retire_cnt SHALL increment on every o_retire, wrapping modulo 2^CNT_W.
REQ-029 o_stall_cnt SHALL increment on each cycle with o_busy & i_stall & ~i_flush, saturating at 2^CNT_W-1.

Reset
REQ-030 i_reset_n=0 SHALL immediately force IDLE, o_stage_act=0, o_stage_idx=0, o_retire=0, o_busy=0, o_halted=1, both counters 0.
REQ-031 Reset mid-instruction SHALL discard it without retire; the first edge after release SHALL evaluate IDLE rules.

Configuration
REQ-032 Macro SEQ_PERF_CNT_EN defined: o_retire_cnt and o_stall_cnt SHALL be implemented as per REQ-028/029.
REQ-033 Macro SEQ_PERF_CNT_EN undefined: both counter ports SHALL remain and be driven constant 0, with no counter flops inferred.

Verification (NUM_STAGES=4, CNT_W=32, SEQ_PERF_CNT_EN defined)
REQ-034 Reset, i_run=1 held for 12 cycles, no stall -> o_stage_idx 0,1,2,3 repeating, o_retire on cycles 4, 8 and 12, o_retire_cnt=3.
REQ-035 RUN, i_stall=1 for 3 cycles at stage 2 -> idx=2 for 4 cycles, o_stage_en[2] low for 3 cycles then high, o_stall_cnt=3.
REQ-036 IDLE, i_step pulse, second pulse 2 cycles later -> exactly 4 busy cycles, one retire, o_halted=1 afterwards, o_retire_cnt=1.
REQ-037 RUN at stage 3 with i_stall=1 and i_flush=1 -> next idx=0, no o_retire, o_retire_cnt unchanged, o_stall_cnt unchanged.
REQ-038 RUN, i_run dropped at stage 1 -> stages 2 and 3 complete, one retire, then o_halted=1.
REQ-039 i_reset_n pulsed low at stage 2 -> all outputs reach REQ-030 values before the next clock edge.

Source files
------------

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: IDLE/RUN/STEP FSM walking a one-hot stage through NUM_STAGES phases.
// Optional performance counters are built only when SEQ_PERF_CNT_EN is defined.
module phase_sequencer #(
   parameter int NUM_STAGES = 4,
   parameter int CNT_W      = 32,
   parameter int IDX_W      = $clog2(NUM_STAGES)
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_run,
   input  logic                  i_step,
   input  logic                  i_stall,
   input  logic                  i_flush,
   output logic [NUM_STAGES-1:0] o_stage_act,
   output logic [NUM_STAGES-1:0] o_stage_en,
   output logic [IDX_W-1:0]      o_stage_idx,
   output logic                  o_retire,
   output logic                  o_busy,
   output logic                  o_halted,
   output logic [CNT_W-1:0]      o_retire_cnt,
   output logic [CNT_W-1:0]      o_stall_cnt,
   output logic [1:0]            o_fsm_state
);

   // Handshake: a stage commits in any busy cycle with i_stall=0 and i_flush=0;
   // i_flush wins over i_stall and over the last-stage commit.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              busy;
   logic              commit;
   logic              last_commit;
   logic [NUM_STAGES-1:0] act;

   assign busy        = (state_q != ST_IDLE);
   assign commit      = busy & ~i_stall & ~i_flush;
   assign last_commit = commit & (idx_q == LAST_IDX);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            idx_d = '0;
            if (i_run)       state_d = ST_RUN;
            else if (i_step) state_d = ST_STEP;
         end
         ST_RUN, ST_STEP: begin
            // Flush and retire share the same exit rule: only RUN with i_run held keeps going.
            if (i_flush) begin
               idx_d   = '0;
               state_d = (state_q == ST_RUN && i_run) ? ST_RUN : ST_IDLE;
            end else if (!i_stall) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = (state_q == ST_RUN && i_run) ? ST_RUN : ST_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      act         = busy ? (NUM_STAGES'(1) << idx_q) : '0;
      o_stage_act = act;
      o_stage_en  = act & ~{NUM_STAGES{i_stall}} & ~{NUM_STAGES{i_flush}};
      o_stage_idx = idx_q;
      o_retire    = last_commit;
      o_busy      = busy;
      o_halted    = ~busy;
      o_fsm_state = state_q;
   end

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] retire_cnt_q;
   logic [CNT_W-1:0] stall_cnt_q;

   // Retire count wraps; stall count saturates so long stalls never read as short ones.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         retire_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         if (last_commit)
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
         if (busy && i_stall && !i_flush && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign o_retire_cnt = retire_cnt_q;
   assign o_stall_cnt  = stall_cnt_q;
`else
   assign o_retire_cnt = '0;
   assign o_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (NUM_STAGES=4): vector table applied per cycle,
// plus hand-written reset sequences. Counter expectations follow SEQ_PERF_CNT_EN.
module tb_phase_sequencer;

   localparam int NS  = 4;
   localparam int CW  = 32;
   localparam int IW  = 2;
`ifdef SEQ_PERF_CNT_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          run = 1'b0, step = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [NS-1:0] stage_act, stage_en;
   logic [IW-1:0] stage_idx;
   logic          retire, busy, halted;
   logic [CW-1:0] retire_cnt, stall_cnt;
   logic [1:0]    fsm_state;

   phase_sequencer #(.NUM_STAGES(NS), .CNT_W(CW), .IDX_W(IW)) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_run        (run),
      .i_step       (step),
      .i_stall      (stall),
      .i_flush      (flush),
      .o_stage_act  (stage_act),
      .o_stage_en   (stage_en),
      .o_stage_idx  (stage_idx),
      .o_retire     (retire),
      .o_busy       (busy),
      .o_halted     (halted),
      .o_retire_cnt (retire_cnt),
      .o_stall_cnt  (stall_cnt),
      .o_fsm_state  (fsm_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic run, step, stall, flush;
      int   idx;
      logic busy, ret;
   } vec_t;

   vec_t vq[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_retire_cnt = 0;
   int   exp_stall_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic add(input logic r, input logic s, input logic st, input logic f,
                      input int idx, input logic b, input logic ret);
      vec_t v;
      v.run = r; v.step = s; v.stall = st; v.flush = f;
      v.idx = idx; v.busy = b; v.ret = ret;
      vq.push_back(v);
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, " retire_cnt"}, retire_cnt, PERF_EN ? 32'(exp_retire_cnt) : 32'd0);
      chk({tag, " stall_cnt"},  stall_cnt,  PERF_EN ? 32'(exp_stall_cnt)  : 32'd0);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, " idx"},    32'(stage_idx), 32'd0);
      chk({tag, " act"},    32'(stage_act), 32'd0);
      chk({tag, " en"},     32'(stage_en),  32'd0);
      chk({tag, " retire"}, 32'(retire),    32'd0);
      chk({tag, " busy"},   32'(busy),      32'd0);
      chk({tag, " halted"}, 32'(halted),    32'd1);
      chk({tag, " retire_cnt"}, retire_cnt, 32'd0);
      chk({tag, " stall_cnt"},  stall_cnt,  32'd0);
   endtask

   task automatic fill_table();
      // Continuous run for 12 instruction cycles.
      add(1,0,0,0, 0,0,0);
      for (int r = 0; r < 3; r++)
         for (int s = 0; s < 4; s++)
            add(1,0,0,0, s,1, logic'(s == 3));
      // i_run dropped at stage 1: instruction completes, then halt.
      add(1,0,0,0, 0,1,0); add(0,0,0,0, 1,1,0); add(0,0,0,0, 2,1,0);
      add(0,0,0,0, 3,1,1); add(0,0,0,0, 0,0,0);
      // Three stall cycles at stage 2.
      add(1,0,0,0, 0,0,0); add(1,0,0,0, 0,1,0); add(1,0,0,0, 1,1,0);
      add(1,0,1,0, 2,1,0); add(1,0,1,0, 2,1,0); add(1,0,1,0, 2,1,0);
      add(1,0,0,0, 2,1,0); add(1,0,0,0, 3,1,1);
      // Stall+flush at last stage: no retire, restart at stage 0.
      add(1,0,0,0, 0,1,0); add(1,0,0,0, 1,1,0); add(1,0,0,0, 2,1,0);
      add(1,0,1,1, 3,1,0);
      add(0,0,0,0, 0,1,0); add(0,0,0,0, 1,1,0); add(0,0,0,0, 2,1,0);
      add(0,0,0,0, 3,1,1); add(0,0,0,0, 0,0,0);
      // Flush in RUN with i_run low halts; stall/flush in IDLE are inert.
      add(1,0,0,0, 0,0,0); add(0,0,0,1, 0,1,0); add(0,0,1,1, 0,0,0);
      add(0,0,0,0, 0,0,0);
      // Single step with a second pulse ignored; run high at step retire still halts.
      add(0,1,0,0, 0,0,0); add(0,0,0,0, 0,1,0); add(0,1,0,0, 1,1,0);
      add(0,0,0,0, 2,1,0); add(1,0,0,0, 3,1,1); add(0,0,0,0, 0,0,0);
      add(0,0,0,0, 0,0,0);
      // Flush in STEP returns to IDLE even with i_run high.
      add(0,1,0,0, 0,0,0); add(0,0,0,0, 0,1,0); add(1,0,0,1, 1,1,0);
      add(0,0,0,0, 0,0,0);
      // i_run wins over i_step in IDLE; RUN continues past retire while i_run high.
      add(1,1,0,0, 0,0,0); add(0,0,0,0, 0,1,0); add(0,1,0,0, 1,1,0);
      add(0,0,0,0, 2,1,0); add(1,0,0,0, 3,1,1); add(0,0,0,0, 0,1,0);
      add(0,0,0,0, 1,1,0); add(0,0,0,0, 2,1,0); add(0,0,0,0, 3,1,1);
      add(0,0,0,0, 0,0,0);
   endtask

   initial begin
      logic [NS-1:0] e_act, e_en;
      fill_table();

      // Reset held: outputs at reset values.
      #2;
      chk_reset_values("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         @(negedge clk);
         run = vq[i].run; step = vq[i].step; stall = vq[i].stall; flush = vq[i].flush;
         #1;
         e_act = vq[i].busy ? (NS'(1) << vq[i].idx) : '0;
         e_en  = (vq[i].stall || vq[i].flush) ? '0 : e_act;
         chk($sformatf("v%0d idx", i),    32'(stage_idx), 32'(vq[i].busy ? vq[i].idx : 0));
         chk($sformatf("v%0d act", i),    32'(stage_act), 32'(e_act));
         chk($sformatf("v%0d en", i),     32'(stage_en),  32'(e_en));
         chk($sformatf("v%0d retire", i), 32'(retire),    32'(vq[i].ret));
         chk($sformatf("v%0d busy", i),   32'(busy),      32'(vq[i].busy));
         chk($sformatf("v%0d halted", i), 32'(halted),    32'(!vq[i].busy));
         chk_counters($sformatf("v%0d", i));
         if (vq[i].ret) exp_retire_cnt++;
         if (vq[i].busy && vq[i].stall && !vq[i].flush) exp_stall_cnt++;
      end

      // Asynchronous reset mid-instruction at stage 2 (while stalled).
      @(negedge clk); run = 1'b1; step = 1'b0; stall = 1'b0; flush = 1'b0;
      @(negedge clk); #1 chk("pre_reset idx0", 32'(stage_idx), 32'd0);
      @(negedge clk);
      @(negedge clk); stall = 1'b1;
      #1 chk("pre_reset idx2", 32'(stage_idx), 32'd2);
      #2 rst_n = 1'b0;
      #1 chk_reset_values("async_reset");
      @(negedge clk);
      chk_reset_values("reset_across_edge");
      stall = 1'b0;
      rst_n = 1'b1;
      #1 chk("post_release halted", 32'(halted), 32'd1);
      @(negedge clk); #1;
      chk("post_release busy", 32'(busy), 32'd1);
      chk("post_release idx", 32'(stage_idx), 32'd0);
      chk("post_release act", 32'(stage_act), 32'd1);
      run = 1'b0;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk); #1;
         chk($sformatf("post_release idx%0d", k), 32'(stage_idx), 32'(k));
         chk($sformatf("post_release retire%0d", k), 32'(retire), 32'(k == 3));
      end
      @(negedge clk); #1;
      chk("final halted", 32'(halted), 32'd1);
      chk("final retire_cnt", retire_cnt, PERF_EN ? 32'd1 : 32'd0);
      chk("final stall_cnt", stall_cnt, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
